// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline.
//
// Latches the EXE result bus and picks up the data-SRAM read data for loads that EXE
// issued in the previous cycle. It then selects the byte or halfword, sign- or
// zero-extends it, and passes the final result to WB. It also drives the forwarding bus
// back to decode.
//
// The SRAM returns read data only in the first cycle a load sits in MEM. If WB stalls
// during that cycle, the data is captured into a hold buffer (rbuf). The stage then
// reads the buffer until the instruction leaves.
//
// Ports:
//   clk                clock
//   reset              synchronous, active-high reset
//   ws_allowin_i       WB can accept an instruction this cycle
//   ms_allowin_o       MEM can accept an instruction this cycle
//   es_to_ms_valid_i   EXE presents a valid instruction
//   es_to_ms_bus_i     {ld_type[73:71], res_from_mem[70], gr_we[69], dest[68:64],
//                       alu_result[63:32], pc[31:0]}
//   ms_to_ws_valid_o   MEM presents a valid instruction to WB
//   ms_to_ws_bus_o     {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
//   ms_to_ds_bus_o     {ms_valid[38], gr_we[37], dest[36:32], final_result[31:0]}
//   data_sram_rdata_i  SRAM read data, valid in the first cycle a load is held in MEM
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 74,
  parameter int unsigned MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin_i,
  output logic                       ms_allowin_o,
  input  logic                       es_to_ms_valid_i,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_i,
  output logic                       ms_to_ws_valid_o,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus_o,
  output logic [38:0]                ms_to_ds_bus_o,
  input  logic [31:0]                data_sram_rdata_i
);

  typedef enum logic [0:0] {StFresh, StHeld} rbuf_st_e;

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic [31:0]                rbuf_q, rbuf_d;
  rbuf_st_e                   rbuf_st_q, rbuf_st_d;

  logic        ms_ready_go;
  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [1:0]  addr;

  logic        rbuf_v;
  logic        rbuf_capture;
  logic [31:0] rdata_eff;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign ld_type      = bus_q[73:71];
  assign res_from_mem = bus_q[70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign alu_result   = bus_q[63:32];
  assign pc           = bus_q[31:0];
  assign addr         = alu_result[1:0];

  // Handshake
  assign ms_ready_go      = 1'b1;
  assign ms_allowin_o     = !ms_valid_q || (ms_ready_go && ws_allowin_i);
  assign ms_to_ws_valid_o = ms_valid_q && ms_ready_go;

  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    if (ms_allowin_o) begin
      ms_valid_d = es_to_ms_valid_i;
    end
    if (es_to_ms_valid_i && ms_allowin_o) begin
      bus_d = es_to_ms_bus_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      bus_q      <= bus_d;
    end
  end

  // Read-data hold buffer FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_st_q <= StFresh;
      rbuf_q    <= '0;
    end else begin
      rbuf_st_q <= rbuf_st_d;
      rbuf_q    <= rbuf_d;
    end
  end

  // Read-data hold buffer FSM: next state
  always_comb begin
    rbuf_st_d = rbuf_st_q;
    unique case (rbuf_st_q)
      StFresh: begin
        // The SRAM drops the data after this cycle, so keep it if the load cannot leave
        if (ms_valid_q && res_from_mem && !ws_allowin_i) begin
          rbuf_st_d = StHeld;
        end
      end
      StHeld: begin
        if (ms_allowin_o) begin
          rbuf_st_d = StFresh;
        end
      end
      default: rbuf_st_d = StFresh;
    endcase
  end

  // Read-data hold buffer FSM: outputs
  always_comb begin
    rbuf_v       = (rbuf_st_q == StHeld);
    rbuf_capture = (rbuf_st_q == StFresh) && ms_valid_q && res_from_mem && !ws_allowin_i;
    rbuf_d       = rbuf_capture ? data_sram_rdata_i : rbuf_q;
    rdata_eff    = rbuf_v ? rbuf_q : data_sram_rdata_i;
  end

  // Load byte/halfword selection and extension
  always_comb begin
    byte_sel = rdata_eff[7:0];
    unique case (addr)
      2'd0:    byte_sel = rdata_eff[7:0];
      2'd1:    byte_sel = rdata_eff[15:8];
      2'd2:    byte_sel = rdata_eff[23:16];
      2'd3:    byte_sel = rdata_eff[31:24];
      default: byte_sel = rdata_eff[7:0];
    endcase
    half_sel = addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    case (ld_type)
      3'b001:  load_result = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_result = {24'd0, byte_sel};
      3'b011:  load_result = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_result = {16'd0, half_sel};
      default: load_result = rdata_eff;
    endcase

    final_result = res_from_mem ? load_result : alu_result;
  end

  assign ms_to_ws_bus_o = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus_o = {ms_valid_q, gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ws_allowin = 1'b0;
  logic        ms_allowin;
  logic        es_to_ms_valid = 1'b0;
  logic [73:0] es_to_ms_bus = '0;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;
  logic [31:0] data_sram_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Instructions currently inside MEM, each with the WB bus it must produce
  logic [69:0] sb[$];

  // Instruction driven this cycle that the stage will accept at the next edge
  logic        acc_pend = 1'b0;
  logic [69:0] acc_exp;
  logic [31:0] acc_word;

  mem_stage #(
    .ES_TO_MS_BUS_WD(74),
    .MS_TO_WS_BUS_WD(70)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin_i     (ws_allowin),
    .ms_allowin_o     (ms_allowin),
    .es_to_ms_valid_i (es_to_ms_valid),
    .es_to_ms_bus_i   (es_to_ms_bus),
    .ms_to_ws_valid_o (ms_to_ws_valid),
    .ms_to_ws_bus_o   (ms_to_ws_bus),
    .ms_to_ds_bus_o   (ms_to_ds_bus),
    .data_sram_rdata_i(data_sram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: MIPS load semantics using plain shifts and arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] addr,
                                           input logic [31:0] word);
    int unsigned b;
    int unsigned h;
    b = (word >> (8 * addr)) & 32'hFF;
    h = (word >> (16 * (addr / 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  // One cycle: retire the previous acceptance into the model, then drive new inputs.
  // word is the SRAM data this instruction's load will see in its first MEM cycle.
  task automatic step(input logic v, input logic [2:0] lt, input logic rfm, input logic we,
                      input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc,
                      input logic ws, input logic [31:0] word);
    logic [31:0] res;
    @(posedge clk);
    #1;
    if (acc_pend) begin
      sb.push_back(acc_exp);
      data_sram_rdata = acc_word;
    end else begin
      data_sram_rdata = $urandom;
    end
    es_to_ms_valid = v;
    es_to_ms_bus   = {lt, rfm, we, dst, alu, pc};
    ws_allowin     = ws;
    res            = rfm ? ref_load(lt, alu[1:0], word) : alu;
    acc_pend       = v && (sb.size() == 0 || ws);
    acc_exp        = {we, dst, res, pc};
    acc_word       = word;
  endtask

  task automatic idle(input logic ws);
    step(1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, ws, 32'd0);
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    acc_pend = 1'b0;
    sb.delete();
    data_sram_rdata = $urandom;
  endtask

  // Monitor: compares DUT outputs with the model once inputs are settled
  always @(negedge clk) begin
    if (!reset) begin
      check("ms_to_ws_valid", {69'd0, ms_to_ws_valid}, {69'd0, sb.size() != 0});
      check("ms_allowin", {69'd0, ms_allowin}, {69'd0, sb.size() == 0 || ws_allowin});
      check("ds_valid", {69'd0, ms_to_ds_bus[38]}, {69'd0, sb.size() != 0});
      if (sb.size() != 0) begin
        check("ds_bus", {32'd0, ms_to_ds_bus[37:0]}, {32'd0, sb[0][69:32]});
        if (ws_allowin) begin
          check("ws_bus", ms_to_ws_bus, sb[0]);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    repeat (3) idle(1'b1);

    // ALU result passes through
    step(1'b1, 3'd0, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'hBFC0_0000, 1'b1, 32'h0);
    idle(1'b1);

    // LB / LBU / LH extension, back-to-back
    step(1'b1, 3'd1, 1'b1, 1'b1, 5'd4, 32'h1000_0001, 32'hBFC0_0004, 1'b1, 32'h0000_8000);
    step(1'b1, 3'd2, 1'b1, 1'b1, 5'd5, 32'h1000_0001, 32'hBFC0_0008, 1'b1, 32'h0000_8000);
    step(1'b1, 3'd3, 1'b1, 1'b1, 5'd6, 32'h1000_0002, 32'hBFC0_000C, 1'b1, 32'h8001_0000);
    idle(1'b1);

    // LW held across a 3-cycle WB stall while the SRAM port changes
    step(1'b1, 3'd0, 1'b1, 1'b1, 5'd7, 32'h1000_0010, 32'hBFC0_0010, 1'b1, 32'hDEAD_BEEF);
    repeat (3) idle(1'b0);
    idle(1'b1);

    // LW then ADD back to back
    step(1'b1, 3'd0, 1'b1, 1'b1, 5'd8, 32'h1000_0020, 32'hBFC0_0014, 1'b1, 32'hCAFE_F00D);
    step(1'b1, 3'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0042, 32'hBFC0_0018, 1'b1, 32'h0);
    idle(1'b1);

    // Reset during a held load, then a fresh load must use new SRAM data
    step(1'b1, 3'd0, 1'b1, 1'b1, 5'd10, 32'h1000_0030, 32'hBFC0_001C, 1'b1, 32'h1111_2222);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    idle(1'b1);
    step(1'b1, 3'd4, 1'b1, 1'b1, 5'd11, 32'h1000_0033, 32'hBFC0_0020, 1'b0, 32'h89AB_CDEF);
    idle(1'b0);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom);
    end

    // Drain
    repeat (4) idle(1'b1);
    @(posedge clk);
    #1;
    check("drained", 70'(sb.size()), 70'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
